// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for the pipelined logic unit
interface logic_unit_pipe_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ones;
  logic             parity;
  logic [CNT_W-1:0] op_cnt;
  modport master (
    output in_valid, op, a, b, mask, out_ready,
    input  in_ready, out_valid, out, zero, ones, parity, op_cnt
  );
  modport slave (
    input  in_valid, op, a, b, mask, out_ready,
    output in_ready, out_valid, out, zero, ones, parity, op_cnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: masked bitwise logic unit with result flags behind a 2-entry skid buffer
module logic_unit_pipe #(
  parameter int WIDTH   = 16,
  parameter bit MASK_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);
  localparam int EW = WIDTH + 3;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           state_q, state_d;
  logic [EW-1:0]    e0_q, e0_d, e1_q, e1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m, f, r;
  logic [EW-1:0]    ent;
  logic             push, pop;
  // result datapath, handshakes and buffer next-state
  always_comb begin
    m = MASK_EN ? bus.mask : '1;
    case (bus.op)
      3'b000:  f = bus.a & bus.b;
      3'b001:  f = bus.a | bus.b;
      3'b010:  f = bus.a ^ bus.b;
      3'b011:  f = ~(bus.a ^ bus.b);
      3'b100:  f = ~(bus.a & bus.b);
      3'b101:  f = ~(bus.a | bus.b);
      3'b110:  f = ~bus.a;
      default: f = bus.a;
    endcase
    r = (f & m) | (bus.a & ~m);
    ent = {^r, &r, ~|r, r};
    push = bus.in_valid & (state_q != TWO);
    pop = (state_q != EMPTY) & bus.out_ready;
    state_d = state_q;
    e0_d = e0_q;
    e1_d = e1_q;
    cnt_d = cnt_q + CNT_W'(pop);
    case (state_q)
      EMPTY: begin
        state_d = push ? ONE : EMPTY;
        e0_d = push ? ent : e0_q;
      end
      ONE: begin
        state_d = (push && !pop) ? TWO : (pop && !push) ? EMPTY : ONE;
        e1_d = (push && !pop) ? ent : e1_q;
        e0_d = (push && pop) ? ent : e0_q;
      end
      TWO: begin
        state_d = pop ? ONE : TWO;
        e0_d = pop ? e1_q : e0_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  // buffer state, entries and pop counter; reset discards everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      e0_q <= '0;
      e1_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.in_ready = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out = e0_q[WIDTH-1:0];
  assign bus.zero = e0_q[WIDTH];
  assign bus.ones = e0_q[WIDTH+1];
  assign bus.parity = e0_q[WIDTH+2];
  assign bus.op_cnt = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for the pipelined logic unit
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0;
  int n_err = 0;
  logic [18:0] q[$];
  logic [3:0] cnt_m = '0;
  logic [3:0] cnt_start;
  logic_unit_pipe_if #(.WIDTH(16), .CNT_W(4)) bus ();
  logic_unit_pipe #(.WIDTH(16), .MASK_EN(1'b1), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a, b, m);
    logic [15:0] f, r;
    case (op)
      3'd0: f = a & b;
      3'd1: f = a | b;
      3'd2: f = a ^ b;
      3'd3: f = ~(a ^ b);
      3'd4: f = ~(a & b);
      3'd5: f = ~(a | b);
      3'd6: f = ~a;
      default: f = a;
    endcase
    r = (f & m) | (a & ~m);
    return {^r, r == 16'hFFFF, r == 16'h0000, r};
  endfunction
  task automatic drive(input logic iv, input logic [2:0] op, input logic [15:0] a, b, m,
                       input logic ordy);
    bus.in_valid = iv;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.mask = m;
    bus.out_ready = ordy;
  endtask
  task automatic tick();
    logic [18:0] e;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("spurious_pop", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("sb_out", 32'(bus.out), 32'(e[15:0]));
        check("sb_flags", 32'({bus.parity, bus.ones, bus.zero}), 32'(e[18:16]));
        check("sb_cnt", 32'(bus.op_cnt), 32'(cnt_m));
        cnt_m = cnt_m + 4'd1;
      end
    end
    if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op, bus.a, bus.b, bus.mask));
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'hFFFF, 1'b0);
    #22;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_op_cnt", 32'(bus.op_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 3'b011, 16'hF0F0, 16'hFF00, 16'hFFFF, 1'b1);
    tick();
    check("xnor_valid", 32'(bus.out_valid), 32'd1);
    check("xnor_out", 32'(bus.out), 32'hF00F);
    check("xnor_flags", 32'({bus.parity, bus.ones, bus.zero}), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    check("xnor_cnt", 32'(bus.op_cnt), 32'd1);
    drive(1'b1, 3'b000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1);
    tick();
    check("and_out", 32'(bus.out), 32'd0);
    check("and_zero", 32'(bus.zero), 32'd1);
    drive(1'b1, 3'b100, 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
    tick();
    check("nand_out", 32'(bus.out), 32'hFFFF);
    check("nand_ones", 32'(bus.ones), 32'd1);
    check("nand_parity", 32'(bus.parity), 32'd0);
    drive(1'b1, 3'b010, 16'h00FF, 16'hFFFF, 16'h0F0F, 1'b1);
    tick();
    check("mask_out", 32'(bus.out), 32'h0FF0);
    bus.in_valid = 1'b0;
    tick();
    cnt_start = cnt_m;
    drive(1'b1, 3'b111, 16'd1, 16'h0, 16'hFFFF, 1'b0);
    tick();
    check("skid_rdy1", 32'(bus.in_ready), 32'd1);
    bus.a = 16'd2;
    tick();
    check("skid_rdy2", 32'(bus.in_ready), 32'd0);
    check("skid_hold", 32'(bus.out), 32'd1);
    bus.a = 16'd3;
    tick();
    check("skid_hold2", 32'(bus.out), 32'd1);
    check("skid_rdy3", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("drain_2", 32'(bus.out), 32'd2);
    tick();
    check("drain_3", 32'(bus.out), 32'd3);
    bus.in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(bus.out_valid), 32'd0);
    check("drain_cnt", 32'(bus.op_cnt), 32'(4'(cnt_start + 4'd3)));
    drive(1'b1, 3'b001, 16'h1234, 16'h00F0, 16'hFFFF, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out", 32'(bus.out), 32'd0);
    check("mid_rst_cnt", 32'(bus.op_cnt), 32'd0);
    check("mid_rst_flags", 32'({bus.parity, bus.ones, bus.zero}), 32'd0);
    q.delete();
    cnt_m = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), $urandom_range(0, 2) != 0);
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'hFFFF, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("sb_empty", 32'(q.size()), 32'd0);
    check("final_cnt", 32'(bus.op_cnt), 32'(cnt_m));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
